axi4_port_bridge: RTL and testbench
===================================

# axi4_port_bridge

Parametrised AXI4 bridge between one RocketChip AXI4 port (mem, mmio or slave DMA) and the 64-bit system interconnect. It replaces hand-wired port hookups and fixed-width address zero-padding. Per port it provides:
- a registered skid buffer on all five channels,
- zero-extension of the address plus a programmable base offset,
- a limit on outstanding reads and writes.

One instance per port. Instances can be cascaded for timing closure.

## Interface
Parameters:
- ID_W, 5, AXI ID width on both sides
- DATA_W, 64, data width; strobe width is DATA_W/8
- IN_ADDR_W, 32, upstream (s side) address width
- OUT_ADDR_W, 64, downstream (m side) address width; must be ≥ IN_ADDR_W
- ADDR_BASE, 64'h0, constant added to the zero-extended address, modulo 2^OUT_ADDR_W
- MAX_OUTSTANDING, 8, maximum in-flight transactions per direction (1..255)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- s_aw_valid / s_aw_ready  in / out  1  upstream write-address handshake
- s_aw_id, addr, len, size, burst, lock, cache, prot, qos  in  ID_W, IN_ADDR_W, 8, 3, 2, 1, 4, 3, 4  AW payload
- s_w_valid / s_w_ready  in / out  1; s_w_data, strb, last  in  DATA_W, DATA_W/8, 1  W channel
- s_b_valid / s_b_ready  out / in  1; s_b_id, resp  out  ID_W, 2  B channel
- s_ar_*  same set and widths as s_aw_*  upstream read-address channel
- s_r_valid / s_r_ready  out / in  1; s_r_id, data, resp, last  out  ID_W, DATA_W, 2, 1  R channel
- m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  mirror of s_* with directions inverted; m_aw_addr and m_ar_addr are OUT_ADDR_W wide

## Operation
Skid buffers:
- Each of the five channels has an independent 2-entry skid buffer (output register plus spill register).
- Payload passes unchanged except AW/AR addr: m_addr = zero_extend(s_addr) + ADDR_BASE, truncated to OUT_ADDR_W.

Outstanding-transaction counters:
- wr_cnt increments on the s_aw handshake and decrements on the s_b handshake.
- rd_cnt increments on the s_ar handshake and decrements on the s_r handshake with last=1.
- Simultaneous increment and decrement leaves the counter unchanged.
- Counter width is $clog2(MAX_OUTSTANDING+1).

Ready gating:
- s_aw_ready = aw skid not full AND wr_cnt < MAX_OUTSTANDING. s_ar_ready uses the same rule with rd_cnt.
- W is not gated. Write data may lead AW, as AXI permits.

Responses are forwarded in arrival order. The bridge performs no ID reordering and no response generation.

## Timing
- Reset values: all *_valid outputs 0, all *_ready outputs 0, wr_cnt = rd_cnt = 0, skid buffers empty.
- Readies rise 1 cycle after reset_n deasserts, via a registered release flag. The flag rises synchronously.
- Latency is exactly 1 cycle from an s-side handshake to m_valid (and vice versa for B/R). Throughput is 1 beat per cycle per channel.
- A skid buffer holds 2 beats under downstream backpressure. Its input ready drops the cycle after the spill register fills and is itself registered: no combinational path from any m_*_ready to any s_*_ready.
- Once asserted, m_valid and its payload stay stable until the handshake.
- At wr_cnt = MAX_OUTSTANDING, s_aw_ready is 0. If a B handshake occurs that cycle, s_aw_ready is 1 the next cycle.
- Reset mid-burst: all state clears immediately. In-flight beats are dropped, and the system reset covers both neighbours.

## Configuration
AXI4_PORT_BRIDGE_STATS_EN:
- Defined: adds outputs stat_wr_done, stat_rd_done and stat_err. Each is 32 bits, saturating, reset to 0.
- They count s_b handshakes, s_r last handshakes, and B/R handshakes with resp ≠ 2'b00 respectively.
- Undefined: these ports and their registers are absent.
- Datapath behaviour is identical either way.

## Structure
Package axi4_port_pkg holds:
- the AXI4 response codes (OKAY, EXOKAY, SLVERR, DECERR),
- the burst codes,
- a typedef for the AW/AR payload struct, parametrised via localparams derived from the widths.

One sub-module, axi4_skid_buf (parameter WIDTH), is instantiated five times with payloads packed into vectors. The counters, address arithmetic and stats stay in the top module.

## Test plan
- Single write: AW addr 32'h8000_0000 with ADDR_BASE = 64'h1_0000_0000 → m_aw_addr = 64'h1_8000_0000 one cycle later; B resp OKAY is returned after 1 cycle.
- Streaming: 16-beat read burst with m_r_ready and s_r_ready held 1 → 16 consecutive s_r beats, no bubbles, last on beat 16.
- Backpressure: m_w_ready = 0 while upstream drives 4 W beats → exactly 2 accepted, then s_w_ready = 0; data is in order and intact after release.
- Limit: MAX_OUTSTANDING = 2, issue 3 ARs with no R → the third is stalled until the first R last handshake, then accepted the next cycle.
- Simultaneous: with wr_cnt = MAX_OUTSTANDING, a B handshake and a new s_aw_valid in the same cycle → the AW is accepted the next cycle and wr_cnt is unchanged.
- Stats (macro defined): 3 writes, one with B resp SLVERR → stat_wr_done = 3, stat_err = 1; asserting reset_n = 0 mid-burst clears all counters and valids.

Source files
------------

// File: rtl/axi4_port_pkg.sv
// Shared AXI4 codes and the AW/AR attribute payload for axi4_port_bridge.
package axi4_port_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;

  // Address-channel attributes; id and addr widths vary per port and are packed alongside.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic               lock;
    logic [CACHE_W-1:0] cache;
    logic [PROT_W-1:0]  prot;
    logic [QOS_W-1:0]   qos;
  } axi_ax_attr_t;

  localparam int AX_ATTR_W = $bits(axi_ax_attr_t);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/axi4_skid_buf.sv
// Two-entry registered skid buffer: output register plus spill register.
// Valid/ready: a beat moves when valid and ready are both high at a rising edge;
// in_ready_o depends only on local registers, so no ready path runs combinationally through.
module axi4_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             spill_valid_q, spill_valid_d;
  logic [WIDTH-1:0] spill_data_q, spill_data_d;
  logic             in_fire, out_fire;

  assign in_ready_o  = ~spill_valid_q;
  assign in_fire     = in_valid_i & ~spill_valid_q;
  assign out_fire    = out_valid_q & out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    spill_valid_d = spill_valid_q;
    spill_data_d  = spill_data_q;
    if (spill_valid_q) begin
      if (out_fire) begin
        out_data_d    = spill_data_q;
        spill_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // The spill register only catches a beat that the output register cannot take.
      if (!out_valid_q || out_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        spill_valid_d = 1'b1;
        spill_data_d  = in_data_i;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      spill_valid_q <= 1'b0;
      spill_data_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      spill_valid_q <= spill_valid_d;
      spill_data_q  <= spill_data_d;
    end
  end

endmodule

// File: rtl/axi4_port_bridge.sv
// AXI4 port bridge: skid buffers on all channels, address rebasing, outstanding limits.
// Optional statistics counters are enabled by defining AXI4_PORT_BRIDGE_STATS_EN.
module axi4_port_bridge
  import axi4_port_pkg::*;
#(
  parameter int          ID_W            = 5,
  parameter int          DATA_W          = 64,
  parameter int          IN_ADDR_W       = 32,
  parameter int          OUT_ADDR_W      = 64,
  parameter logic [63:0] ADDR_BASE       = 64'h0,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_aw_valid,
  output logic                  s_aw_ready,
  input  logic [ID_W-1:0]       s_aw_id,
  input  logic [IN_ADDR_W-1:0]  s_aw_addr,
  input  logic [7:0]            s_aw_len,
  input  logic [2:0]            s_aw_size,
  input  logic [1:0]            s_aw_burst,
  input  logic                  s_aw_lock,
  input  logic [3:0]            s_aw_cache,
  input  logic [2:0]            s_aw_prot,
  input  logic [3:0]            s_aw_qos,
  input  logic                  s_w_valid,
  output logic                  s_w_ready,
  input  logic [DATA_W-1:0]     s_w_data,
  input  logic [DATA_W/8-1:0]   s_w_strb,
  input  logic                  s_w_last,
  output logic                  s_b_valid,
  input  logic                  s_b_ready,
  output logic [ID_W-1:0]       s_b_id,
  output logic [1:0]            s_b_resp,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ID_W-1:0]       s_ar_id,
  input  logic [IN_ADDR_W-1:0]  s_ar_addr,
  input  logic [7:0]            s_ar_len,
  input  logic [2:0]            s_ar_size,
  input  logic [1:0]            s_ar_burst,
  input  logic                  s_ar_lock,
  input  logic [3:0]            s_ar_cache,
  input  logic [2:0]            s_ar_prot,
  input  logic [3:0]            s_ar_qos,
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [ID_W-1:0]       s_r_id,
  output logic [DATA_W-1:0]     s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last,
  output logic                  m_aw_valid,
  input  logic                  m_aw_ready,
  output logic [ID_W-1:0]       m_aw_id,
  output logic [OUT_ADDR_W-1:0] m_aw_addr,
  output logic [7:0]            m_aw_len,
  output logic [2:0]            m_aw_size,
  output logic [1:0]            m_aw_burst,
  output logic                  m_aw_lock,
  output logic [3:0]            m_aw_cache,
  output logic [2:0]            m_aw_prot,
  output logic [3:0]            m_aw_qos,
  output logic                  m_w_valid,
  input  logic                  m_w_ready,
  output logic [DATA_W-1:0]     m_w_data,
  output logic [DATA_W/8-1:0]   m_w_strb,
  output logic                  m_w_last,
  input  logic                  m_b_valid,
  output logic                  m_b_ready,
  input  logic [ID_W-1:0]       m_b_id,
  input  logic [1:0]            m_b_resp,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ID_W-1:0]       m_ar_id,
  output logic [OUT_ADDR_W-1:0] m_ar_addr,
  output logic [7:0]            m_ar_len,
  output logic [2:0]            m_ar_size,
  output logic [1:0]            m_ar_burst,
  output logic                  m_ar_lock,
  output logic [3:0]            m_ar_cache,
  output logic [2:0]            m_ar_prot,
  output logic [3:0]            m_ar_qos,
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [ID_W-1:0]       m_r_id,
  input  logic [DATA_W-1:0]     m_r_data,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_last
`ifdef AXI4_PORT_BRIDGE_STATS_EN
  ,
  output logic [31:0]           stat_wr_done,
  output logic [31:0]           stat_rd_done,
  output logic [31:0]           stat_err
`endif
);

  localparam int AW_W  = ID_W + OUT_ADDR_W + AX_ATTR_W;
  localparam int W_W   = DATA_W + DATA_W / 8 + 1;
  localparam int B_W   = ID_W + 2;
  localparam int R_W   = ID_W + DATA_W + 3;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]      MAX_C  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_ADDR_W-1:0] BASE_C = OUT_ADDR_W'(ADDR_BASE);

  logic             rel_q;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             aw_rdy, w_rdy, b_rdy, ar_rdy, r_rdy;
  logic             aw_fire, b_fire, ar_fire, r_fire, r_last_fire;
  axi_ax_attr_t     s_aw_attr, s_ar_attr, m_aw_attr, m_ar_attr;
  logic [AW_W-1:0]  aw_out, ar_out;
  logic [W_W-1:0]   w_out;
  logic [B_W-1:0]   b_out;
  logic [R_W-1:0]   r_out;

  assign s_aw_attr = '{len: s_aw_len, size: s_aw_size, burst: s_aw_burst, lock: s_aw_lock,
                       cache: s_aw_cache, prot: s_aw_prot, qos: s_aw_qos};
  assign s_ar_attr = '{len: s_ar_len, size: s_ar_size, burst: s_ar_burst, lock: s_ar_lock,
                       cache: s_ar_cache, prot: s_ar_prot, qos: s_ar_qos};

  // Readies come only from registers: release flag, skid occupancy, outstanding counters.
  assign s_aw_ready = rel_q & aw_rdy & (wr_cnt_q < MAX_C);
  assign s_ar_ready = rel_q & ar_rdy & (rd_cnt_q < MAX_C);
  assign s_w_ready  = rel_q & w_rdy;
  assign m_b_ready  = rel_q & b_rdy;
  assign m_r_ready  = rel_q & r_rdy;

  assign aw_fire     = s_aw_valid & s_aw_ready;
  assign ar_fire     = s_ar_valid & s_ar_ready;
  assign b_fire      = s_b_valid & s_b_ready;
  assign r_fire      = s_r_valid & s_r_ready;
  assign r_last_fire = r_fire & s_r_last;

  axi4_skid_buf #(.WIDTH(AW_W)) u_aw (
    .clk, .reset_n, .in_valid_i(aw_fire), .in_ready_o(aw_rdy),
    .in_data_i({s_aw_id, OUT_ADDR_W'(s_aw_addr) + BASE_C, s_aw_attr}),
    .out_valid_o(m_aw_valid), .out_ready_i(m_aw_ready), .out_data_o(aw_out));

  axi4_skid_buf #(.WIDTH(W_W)) u_w (
    .clk, .reset_n, .in_valid_i(s_w_valid & s_w_ready), .in_ready_o(w_rdy),
    .in_data_i({s_w_data, s_w_strb, s_w_last}),
    .out_valid_o(m_w_valid), .out_ready_i(m_w_ready), .out_data_o(w_out));

  axi4_skid_buf #(.WIDTH(B_W)) u_b (
    .clk, .reset_n, .in_valid_i(m_b_valid & m_b_ready), .in_ready_o(b_rdy),
    .in_data_i({m_b_id, m_b_resp}),
    .out_valid_o(s_b_valid), .out_ready_i(s_b_ready), .out_data_o(b_out));

  axi4_skid_buf #(.WIDTH(AW_W)) u_ar (
    .clk, .reset_n, .in_valid_i(ar_fire), .in_ready_o(ar_rdy),
    .in_data_i({s_ar_id, OUT_ADDR_W'(s_ar_addr) + BASE_C, s_ar_attr}),
    .out_valid_o(m_ar_valid), .out_ready_i(m_ar_ready), .out_data_o(ar_out));

  axi4_skid_buf #(.WIDTH(R_W)) u_r (
    .clk, .reset_n, .in_valid_i(m_r_valid & m_r_ready), .in_ready_o(r_rdy),
    .in_data_i({m_r_id, m_r_data, m_r_resp, m_r_last}),
    .out_valid_o(s_r_valid), .out_ready_i(s_r_ready), .out_data_o(r_out));

  assign {m_aw_id, m_aw_addr, m_aw_attr}    = aw_out;
  assign {m_ar_id, m_ar_addr, m_ar_attr}    = ar_out;
  assign {m_w_data, m_w_strb, m_w_last}     = w_out;
  assign {s_b_id, s_b_resp}                 = b_out;
  assign {s_r_id, s_r_data, s_r_resp, s_r_last} = r_out;

  assign m_aw_len   = m_aw_attr.len;
  assign m_aw_size  = m_aw_attr.size;
  assign m_aw_burst = m_aw_attr.burst;
  assign m_aw_lock  = m_aw_attr.lock;
  assign m_aw_cache = m_aw_attr.cache;
  assign m_aw_prot  = m_aw_attr.prot;
  assign m_aw_qos   = m_aw_attr.qos;
  assign m_ar_len   = m_ar_attr.len;
  assign m_ar_size  = m_ar_attr.size;
  assign m_ar_burst = m_ar_attr.burst;
  assign m_ar_lock  = m_ar_attr.lock;
  assign m_ar_cache = m_ar_attr.cache;
  assign m_ar_prot  = m_ar_attr.prot;
  assign m_ar_qos   = m_ar_attr.qos;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_fire && !b_fire)      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (!aw_fire && b_fire) wr_cnt_d = wr_cnt_q - CNT_W'(1);
    if (ar_fire && !r_last_fire)      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (!ar_fire && r_last_fire) rd_cnt_d = rd_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rel_q    <= 1'b1;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

`ifdef AXI4_PORT_BRIDGE_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q, stat_err_q;
  logic        b_err, r_err;

  assign b_err = b_fire & (s_b_resp != RESP_OKAY);
  assign r_err = r_fire & (s_r_resp != RESP_OKAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_wr_q  <= sat_add(stat_wr_q, {1'b0, b_fire});
      stat_rd_q  <= sat_add(stat_rd_q, {1'b0, r_last_fire});
      stat_err_q <= sat_add(stat_err_q, {1'b0, b_err} + {1'b0, r_err});
    end
  end

  assign stat_wr_done = stat_wr_q;
  assign stat_rd_done = stat_rd_q;
  assign stat_err     = stat_err_q;
`endif

endmodule

// File: tb/tb_axi4_port_bridge.sv
// Directed bench for axi4_port_bridge (MAX_OUTSTANDING = 2, ADDR_BASE = 64'h1_0000_0000).
module tb_axi4_port_bridge;

  localparam int          ID_W = 5, DATA_W = 64, IN_ADDR_W = 32, OUT_ADDR_W = 64, MAX_OUT = 2;
  localparam logic [63:0] BASE = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic s_aw_valid = 0, s_aw_ready, s_aw_lock = 0;
  logic [ID_W-1:0] s_aw_id = '0;
  logic [31:0] s_aw_addr = '0;
  logic [7:0] s_aw_len = '0;
  logic [2:0] s_aw_size = '0, s_aw_prot = '0;
  logic [1:0] s_aw_burst = '0;
  logic [3:0] s_aw_cache = '0, s_aw_qos = '0;
  logic s_w_valid = 0, s_w_ready, s_w_last = 0;
  logic [63:0] s_w_data = '0;
  logic [7:0] s_w_strb = '0;
  logic s_b_valid, s_b_ready = 0;
  logic [ID_W-1:0] s_b_id;
  logic [1:0] s_b_resp;
  logic s_ar_valid = 0, s_ar_ready, s_ar_lock = 0;
  logic [ID_W-1:0] s_ar_id = '0;
  logic [31:0] s_ar_addr = '0;
  logic [7:0] s_ar_len = '0;
  logic [2:0] s_ar_size = '0, s_ar_prot = '0;
  logic [1:0] s_ar_burst = '0;
  logic [3:0] s_ar_cache = '0, s_ar_qos = '0;
  logic s_r_valid, s_r_ready = 0, s_r_last;
  logic [ID_W-1:0] s_r_id;
  logic [63:0] s_r_data;
  logic [1:0] s_r_resp;
  logic m_aw_valid, m_aw_ready = 0, m_aw_lock;
  logic [ID_W-1:0] m_aw_id;
  logic [63:0] m_aw_addr;
  logic [7:0] m_aw_len;
  logic [2:0] m_aw_size, m_aw_prot;
  logic [1:0] m_aw_burst;
  logic [3:0] m_aw_cache, m_aw_qos;
  logic m_w_valid, m_w_ready = 0, m_w_last;
  logic [63:0] m_w_data;
  logic [7:0] m_w_strb;
  logic m_b_valid = 0, m_b_ready;
  logic [ID_W-1:0] m_b_id = '0;
  logic [1:0] m_b_resp = '0;
  logic m_ar_valid, m_ar_ready = 0, m_ar_lock;
  logic [ID_W-1:0] m_ar_id;
  logic [63:0] m_ar_addr;
  logic [7:0] m_ar_len;
  logic [2:0] m_ar_size, m_ar_prot;
  logic [1:0] m_ar_burst;
  logic [3:0] m_ar_cache, m_ar_qos;
  logic m_r_valid = 0, m_r_ready, m_r_last = 0;
  logic [ID_W-1:0] m_r_id = '0;
  logic [63:0] m_r_data = '0;
  logic [1:0] m_r_resp = '0;
`ifdef AXI4_PORT_BRIDGE_STATS_EN
  logic [31:0] stat_wr_done, stat_rd_done, stat_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  axi4_port_bridge #(
    .ID_W(ID_W), .DATA_W(DATA_W), .IN_ADDR_W(IN_ADDR_W), .OUT_ADDR_W(OUT_ADDR_W),
    .ADDR_BASE(BASE), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
    .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
    .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
    .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
    .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last)
`ifdef AXI4_PORT_BRIDGE_STATS_EN
    ,
    .stat_wr_done(stat_wr_done), .stat_rd_done(stat_rd_done), .stat_err(stat_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write driver: AW, drain, then one B response from the downstream side.
  task automatic do_write(input logic [4:0] id, input logic [1:0] resp);
    s_aw_valid = 1; s_aw_id = id; s_aw_addr = 32'h40; tick();
    s_aw_valid = 0; tick();
    m_b_valid = 1; m_b_id = id; m_b_resp = resp; tick();
    m_b_valid = 0; tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if ({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_readies: got %b want 00000",
        {s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}); end
    n_cmp++; if ({m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids: got %b want 00000",
        {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid}); end
    n_cmp++; if (dut.wr_cnt_q !== 0 || dut.rd_cnt_q !== 0) begin
      n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", dut.wr_cnt_q, dut.rd_cnt_q); end
    s_b_ready = 1; s_r_ready = 1; m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1;
    reset_n = 1;
    n_cmp++; if (s_aw_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_before_release: got %b want 0", s_aw_ready); end
    tick();
    n_cmp++; if ({s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready} !== 5'b11111) begin
      n_bad++; $display("FAIL ready_after_release: got %b want 11111",
        {s_aw_ready, s_w_ready, s_ar_ready, m_b_ready, m_r_ready}); end
  endtask

`ifdef AXI4_PORT_BRIDGE_STATS_EN
  task automatic test_stats();
    do_write(5'd1, 2'b00);
    do_write(5'd2, 2'b10);
    do_write(5'd3, 2'b00);
    n_cmp++; if (stat_wr_done !== 32'd3) begin
      n_bad++; $display("FAIL stat_wr_done: got %0d want 3", stat_wr_done); end
    n_cmp++; if (stat_err !== 32'd1) begin
      n_bad++; $display("FAIL stat_err: got %0d want 1", stat_err); end
    n_cmp++; if (stat_rd_done !== 32'd0) begin
      n_bad++; $display("FAIL stat_rd_done: got %0d want 0", stat_rd_done); end
  endtask
`endif

  task automatic test_reset_mid();
    s_r_ready = 0;
    s_ar_valid = 1; s_ar_id = 5'd2; s_ar_addr = 32'h200; s_ar_len = 8'd3; tick();
    s_ar_valid = 0; tick();
    m_r_valid = 1; m_r_id = 5'd2; m_r_data = 64'h11; m_r_last = 0; tick();
    m_r_data = 64'h22; tick();
    m_r_valid = 0;
    n_cmp++; if ({s_r_valid, m_r_ready} !== 2'b10 || dut.rd_cnt_q !== 1) begin
      n_bad++; $display("FAIL pre_reset_fill: got valid/ready %b cnt %0d want 10 cnt 1",
        {s_r_valid, m_r_ready}, dut.rd_cnt_q); end
    reset_n = 0;
    #1;
    n_cmp++; if ({s_r_valid, m_ar_valid, s_ar_ready, m_r_ready} !== 4'b0) begin
      n_bad++; $display("FAIL mid_reset_clear: got %b want 0000",
        {s_r_valid, m_ar_valid, s_ar_ready, m_r_ready}); end
    n_cmp++; if (dut.rd_cnt_q !== 0 || dut.wr_cnt_q !== 0) begin
      n_bad++; $display("FAIL mid_reset_counters: got %0d/%0d want 0/0", dut.wr_cnt_q, dut.rd_cnt_q); end
`ifdef AXI4_PORT_BRIDGE_STATS_EN
    n_cmp++; if ({stat_wr_done, stat_rd_done, stat_err} !== 96'd0) begin
      n_bad++; $display("FAIL mid_reset_stats: got %0d/%0d/%0d want 0/0/0",
        stat_wr_done, stat_rd_done, stat_err); end
`endif
    tick();
    reset_n = 1; s_r_ready = 1; tick();
    n_cmp++; if ({s_ar_ready, m_r_ready, s_r_valid} !== 3'b110) begin
      n_bad++; $display("FAIL post_reset_state: got %b want 110", {s_ar_ready, m_r_ready, s_r_valid}); end
  endtask

  task automatic test_single_write();
    s_aw_valid = 1; s_aw_id = 5'd3; s_aw_addr = 32'h8000_0000; s_aw_len = 8'd3; s_aw_qos = 4'hA;
    s_w_valid = 1; s_w_data = 64'hDEAD_BEEF_0123_4567; s_w_strb = 8'hF0; s_w_last = 1;
    tick();
    s_aw_valid = 0; s_w_valid = 0;
    n_cmp++; if (m_aw_valid !== 1'b1 || m_aw_addr !== 64'h1_8000_0000) begin
      n_bad++; $display("FAIL aw_addr: got v=%b %h want v=1 0000000180000000", m_aw_valid, m_aw_addr); end
    n_cmp++; if (m_aw_id !== 5'd3 || m_aw_len !== 8'd3 || m_aw_qos !== 4'hA) begin
      n_bad++; $display("FAIL aw_payload: got id %0d len %0d qos %h want 3 3 a", m_aw_id, m_aw_len, m_aw_qos); end
    n_cmp++; if ({m_w_valid, m_w_data, m_w_strb, m_w_last} !== {1'b1, 64'hDEAD_BEEF_0123_4567, 8'hF0, 1'b1}) begin
      n_bad++; $display("FAIL w_payload: got v=%b %h %h %b", m_w_valid, m_w_data, m_w_strb, m_w_last); end
    tick();
    n_cmp++; if ({m_aw_valid, m_w_valid} !== 2'b00) begin
      n_bad++; $display("FAIL aw_w_drain: got %b want 00", {m_aw_valid, m_w_valid}); end
    m_b_valid = 1; m_b_id = 5'd3; m_b_resp = 2'b00; tick();
    m_b_valid = 0;
    n_cmp++; if ({s_b_valid, s_b_id, s_b_resp} !== {1'b1, 5'd3, 2'b00} || dut.wr_cnt_q !== 1) begin
      n_bad++; $display("FAIL b_return: got v=%b id %0d resp %b cnt %0d want 1 3 00 1",
        s_b_valid, s_b_id, s_b_resp, dut.wr_cnt_q); end
    tick();
    n_cmp++; if (s_b_valid !== 1'b0 || dut.wr_cnt_q !== 0) begin
      n_bad++; $display("FAIL b_done: got v=%b cnt %0d want 0 0", s_b_valid, dut.wr_cnt_q); end
  endtask

  task automatic test_stream();
    s_ar_valid = 1; s_ar_id = 5'd1; s_ar_addr = 32'h100; s_ar_len = 8'd15; tick();
    s_ar_valid = 0;
    n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 64'h1_0000_0100 || m_ar_len !== 8'd15) begin
      n_bad++; $display("FAIL ar_fwd: got v=%b %h len %0d", m_ar_valid, m_ar_addr, m_ar_len); end
    tick();
    for (int i = 0; i < 16; i++) begin
      m_r_valid = 1; m_r_id = 5'd1; m_r_data = 64'hA000 + 64'(i); m_r_last = (i == 15);
      tick();
      n_cmp++; if ({s_r_valid, s_r_data, s_r_last} !== {1'b1, 64'hA000 + 64'(i), (i == 15)}) begin
        n_bad++; $display("FAIL stream_beat%0d: got v=%b %h last %b", i, s_r_valid, s_r_data, s_r_last); end
    end
    m_r_valid = 0; m_r_last = 0; tick();
    n_cmp++; if (s_r_valid !== 1'b0 || dut.rd_cnt_q !== 0) begin
      n_bad++; $display("FAIL stream_end: got v=%b cnt %0d want 0 0", s_r_valid, dut.rd_cnt_q); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic rdy;
    logic [63:0] beats [4];
    beats[0] = 64'h1111; beats[1] = 64'h2222; beats[2] = 64'h3333; beats[3] = 64'h4444;
    acc = 0; m_w_ready = 0; s_w_strb = 8'hFF; s_w_last = 0;
    for (int c = 0; c < 6; c++) begin
      s_w_valid = (acc < 4);
      if (acc < 4) s_w_data = beats[acc];
      rdy = s_w_ready;
      tick();
      if (s_w_valid && rdy) begin exp_q.push_back(beats[acc]); acc++; end
    end
    s_w_valid = 0;
    n_cmp++; if (acc !== 2 || s_w_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_accept: got %0d beats ready %b want 2 beats ready 0", acc, s_w_ready); end
    m_w_ready = 1;
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      n_cmp++; if (m_w_valid !== 1'b1 || m_w_data !== e) begin
        n_bad++; $display("FAIL bp_order: got v=%b %h want %h", m_w_valid, m_w_data, e); end
      tick();
    end
    n_cmp++; if (m_w_valid !== 1'b0 || s_w_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got v=%b ready %b want 0 1", m_w_valid, s_w_ready); end
  endtask

  task automatic test_limit();
    s_ar_len = 8'd0; s_ar_valid = 1;
    s_ar_id = 5'd4; tick();
    s_ar_id = 5'd5; tick();
    s_ar_id = 5'd6;
    n_cmp++; if (s_ar_ready !== 1'b0) begin
      n_bad++; $display("FAIL limit_stall: got %b want 0", s_ar_ready); end
    tick();
    n_cmp++; if (s_ar_ready !== 1'b0 || dut.rd_cnt_q !== 2) begin
      n_bad++; $display("FAIL limit_hold: got ready %b cnt %0d want 0 2", s_ar_ready, dut.rd_cnt_q); end
    m_r_valid = 1; m_r_id = 5'd4; m_r_last = 1; tick();
    m_r_valid = 0;
    n_cmp++; if (s_ar_ready !== 1'b0 || s_r_valid !== 1'b1) begin
      n_bad++; $display("FAIL limit_r_pending: got ready %b rv %b want 0 1", s_ar_ready, s_r_valid); end
    tick();
    n_cmp++; if (s_ar_ready !== 1'b1) begin
      n_bad++; $display("FAIL limit_reopen: got %b want 1", s_ar_ready); end
    tick();
    s_ar_valid = 0;
    n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_id !== 5'd6 || dut.rd_cnt_q !== 2) begin
      n_bad++; $display("FAIL limit_third: got v=%b id %0d cnt %0d want 1 6 2", m_ar_valid, m_ar_id, dut.rd_cnt_q); end
    m_r_valid = 1; m_r_id = 5'd5; tick();
    m_r_id = 5'd6; tick();
    m_r_valid = 0; m_r_last = 0; tick(); tick();
    n_cmp++; if (dut.rd_cnt_q !== 0) begin
      n_bad++; $display("FAIL limit_drain: got %0d want 0", dut.rd_cnt_q); end
  endtask

  task automatic test_simultaneous();
    s_aw_valid = 1; s_aw_id = 5'd1; tick();
    s_aw_id = 5'd2; tick();
    s_aw_id = 5'd7;
    n_cmp++; if (s_aw_ready !== 1'b0 || dut.wr_cnt_q !== 2) begin
      n_bad++; $display("FAIL sim_full: got ready %b cnt %0d want 0 2", s_aw_ready, dut.wr_cnt_q); end
    m_b_valid = 1; m_b_id = 5'd1; m_b_resp = 2'b00; tick();
    m_b_valid = 0;
    n_cmp++; if (s_aw_ready !== 1'b0 || s_b_valid !== 1'b1) begin
      n_bad++; $display("FAIL sim_same_cycle: got ready %b bv %b want 0 1", s_aw_ready, s_b_valid); end
    tick();
    n_cmp++; if (s_aw_ready !== 1'b1 || dut.wr_cnt_q !== 1) begin
      n_bad++; $display("FAIL sim_next_cycle: got ready %b cnt %0d want 1 1", s_aw_ready, dut.wr_cnt_q); end
    tick();
    s_aw_valid = 0;
    n_cmp++; if (dut.wr_cnt_q !== 2 || m_aw_id !== 5'd7 || m_aw_valid !== 1'b1) begin
      n_bad++; $display("FAIL sim_accepted: got cnt %0d id %0d v %b want 2 7 1", dut.wr_cnt_q, m_aw_id, m_aw_valid); end
    m_b_valid = 1; m_b_id = 5'd2; tick();
    m_b_id = 5'd7; tick();
    m_b_valid = 0; tick(); tick();
    n_cmp++; if (dut.wr_cnt_q !== 0) begin
      n_bad++; $display("FAIL sim_drain: got %0d want 0", dut.wr_cnt_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef AXI4_PORT_BRIDGE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    test_single_write();
    test_stream();
    test_backpressure();
    test_limit();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
